// File: rtl/seq_alu_if.sv
// Request/response bundle between the issue stage (master) and seq_alu (slave).
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2:0]             op;
  logic [WIDTH-1:0]       src_a;
  logic [WIDTH-1:0]       src_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     result;
  logic                   carry;
  logic                   zero;
  logic                   div_zero;

  modport master (
    output in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, carry, zero, div_zero
  );

  modport slave (
    input  in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, carry, zero, div_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Handshaked integer ALU: single-cycle add/sub/inc/dec/compare/parity plus an
// iterative shift-add multiplier and restoring divider sharing one datapath.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic     Clock,
  input logic     Reset,
  seq_alu_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_INC = 3'd4;
  localparam logic [2:0] OP_DEC = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;
  localparam logic [2:0] OP_PAR = 3'd7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Even parity: 1 when the operand has an even number of set bits.
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ~^v;
  endfunction

  // Zero flag over the full double-width result.
  function automatic logic is_zero(input logic [2*WIDTH-1:0] v);
    return (v == {(2*WIDTH){1'b0}});
  endfunction

  // Sequencing state
  logic [0:0]           state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 is_mul_r;
  // Iterative datapath: opnd_r is multiplicand/divisor, {hi_r,lo_r} is the
  // product (mul) or {remainder, quotient-in-progress} (div).
  logic [WIDTH-1:0]     opnd_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;
  // Held output register
  logic                 out_valid_r;
  logic [2*WIDTH-1:0]   result_r;
  logic                 carry_r;
  logic                 zero_r;
  logic                 div_zero_r;

  logic                 in_ready_s;
  logic                 accept_s;
  logic                 start_iter_s;
  logic [WIDTH:0]       wide_s;
  logic [2*WIDTH-1:0]   sc_result_s;
  logic                 sc_carry_s;
  logic                 sc_div_zero_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH-1:0]     div_diff_s;
  logic                 div_ge_s;
  logic [WIDTH-1:0]     step_hi_s;
  logic [WIDTH-1:0]     step_lo_s;

  assign in_ready_s   = (state_r == ST_IDLE) && (!out_valid_r || bus.out_ready);
  assign accept_s     = bus.in_valid && in_ready_s;
  assign start_iter_s = (bus.op == OP_MUL) ||
                        ((bus.op == OP_DIV) && (bus.src_b != {WIDTH{1'b0}}));

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.carry     = carry_r;
  assign bus.zero      = zero_r;
  assign bus.div_zero  = div_zero_r;

  // Single-cycle results (including divide-by-zero) computed from live inputs.
  always_comb begin
    wide_s        = {(WIDTH+1){1'b0}};
    sc_result_s   = {(2*WIDTH){1'b0}};
    sc_carry_s    = 1'b0;
    sc_div_zero_s = 1'b0;
    case (bus.op)
      OP_ADD: begin
        wide_s                 = {1'b0, bus.src_a} + {1'b0, bus.src_b};
        sc_result_s[WIDTH-1:0] = wide_s[WIDTH-1:0];
        sc_carry_s             = wide_s[WIDTH];
      end
      OP_SUB: begin
        wide_s                 = {1'b0, bus.src_a} - {1'b0, bus.src_b};
        sc_result_s[WIDTH-1:0] = wide_s[WIDTH-1:0];
        sc_carry_s             = wide_s[WIDTH];
      end
      OP_INC: begin
        wide_s                 = {1'b0, bus.src_a} + {{WIDTH{1'b0}}, 1'b1};
        sc_result_s[WIDTH-1:0] = wide_s[WIDTH-1:0];
        sc_carry_s             = wide_s[WIDTH];
      end
      OP_DEC: begin
        wide_s                 = {1'b0, bus.src_a} - {{WIDTH{1'b0}}, 1'b1};
        sc_result_s[WIDTH-1:0] = wide_s[WIDTH-1:0];
        sc_carry_s             = wide_s[WIDTH];
      end
      OP_CMP: begin
        sc_result_s[0] = (bus.src_a == bus.src_b);
        sc_result_s[1] = (bus.src_a > bus.src_b);
        sc_result_s[2] = ($signed(bus.src_a) > $signed(bus.src_b));
      end
      OP_PAR: begin
        sc_result_s[0] = even_parity(bus.src_a);
      end
      OP_DIV: begin
        // Only consumed when the divisor is zero: quotient saturates, remainder = a.
        sc_result_s   = {bus.src_a, {WIDTH{1'b1}}};
        sc_div_zero_s = 1'b1;
      end
      OP_MUL: begin
        sc_result_s = {(2*WIDTH){1'b0}};
      end
      default: begin
        sc_result_s = {(2*WIDTH){1'b0}};
      end
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {hi_r, lo_r[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
    // When div_ge_s holds the true difference is below the divisor, so the
    // low WIDTH bits of the modular subtraction are exact.
    div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_r;
    if (is_mul_r) begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end else begin
      step_hi_s = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
      step_lo_s = {lo_r[WIDTH-2:0], div_ge_s};
    end
  end

  // Request acceptance, iteration sequencing and the held output register.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      is_mul_r    <= 1'b0;
      opnd_r      <= {WIDTH{1'b0}};
      hi_r        <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      result_r    <= {(2*WIDTH){1'b0}};
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      div_zero_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (start_iter_s) begin
              state_r     <= ST_BUSY;
              cnt_r       <= CNT_INIT;
              is_mul_r    <= (bus.op == OP_MUL);
              opnd_r      <= (bus.op == OP_MUL) ? bus.src_a : bus.src_b;
              hi_r        <= {WIDTH{1'b0}};
              lo_r        <= (bus.op == OP_MUL) ? bus.src_b : bus.src_a;
              out_valid_r <= 1'b0;
            end else begin
              result_r    <= sc_result_s;
              carry_r     <= sc_carry_s;
              zero_r      <= is_zero(sc_result_s);
              div_zero_r  <= sc_div_zero_s;
              out_valid_r <= 1'b1;
            end
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        ST_BUSY: begin
          hi_r  <= step_hi_s;
          lo_r  <= step_lo_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r     <= ST_IDLE;
            result_r    <= {step_hi_s, step_lo_s};
            carry_r     <= 1'b0;
            zero_r      <= is_zero({step_hi_s, step_lo_s});
            div_zero_r  <= 1'b0;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
